// File: rtl/turbo_deframer.sv
// Turbo block deframer: buffers K payload symbols plus a 4-beat termination
// tail and holds the frame for the decoder until it is released.
module turbo_deframer #(
  parameter int MAX_LEN = 6144,
  parameter int LEN_W   = 17,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sys,
  input  logic              in_p1,
  input  logic              in_p2,
  output logic              frame_ready,
  output logic [LEN_W-1:0]  frame_len,
  output logic [11:0]       tail,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        rd_data,
  input  logic              frame_done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for first beat of a frame; length checked here
  // DATA  | payload beats 1..K-1 written to buffer
  // TAIL  | four termination beats captured into tail
  // HOLD  | frame complete, frozen until frame_done
  typedef enum logic [1:0] {IDLE, DATA, TAIL, HOLD} state_t;

  state_t             state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic [1:0]         tail_cnt;
  logic [2:0]         beat;
  logic               accept;
  logic               len_ok;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [2:0]         mem [MAX_LEN];

  assign beat     = {in_sys, in_p1, in_p2};
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign len_ok   = (length != '0) && (32'(length) <= MAX_LEN);
  assign cnt_inc  = cnt + LEN_W'(1);
  assign wr_en    = accept && (((state == IDLE) && len_ok) || (state == DATA));
  assign wr_addr  = (state == DATA) ? cnt[ADDR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= beat;
  end

  // Addresses beyond the buffer read back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= (32'(rd_addr) < MAX_LEN) ? mem[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tail_cnt    <= '0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      tail        <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (len_ok) begin
              frame_len <= length;
              tail_cnt  <= '0;
              if (length == LEN_W'(1)) begin
                cnt   <= '0;
                state <= TAIL;
              end else begin
                cnt   <= LEN_W'(1);
                state <= DATA;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (cnt_inc == frame_len) begin
              cnt   <= '0;
              state <= TAIL;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        TAIL: begin
          if (accept) begin
            case (tail_cnt)
              2'd0:    tail[2:0]  <= beat;
              2'd1:    tail[5:3]  <= beat;
              2'd2:    tail[8:6]  <= beat;
              default: tail[11:9] <= beat;
            endcase
            tail_cnt <= tail_cnt + 2'd1;
            if (tail_cnt == 2'd3) begin
              state       <= HOLD;
              frame_ready <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_done) begin
            state       <= IDLE;
            frame_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_deframer.sv
// Randomized bench for turbo_deframer: beat-level reference model plus
// literal checks for the directed frames.
module tb_turbo_deframer;
  localparam int MAX_LEN = 6144;
  localparam int LEN_W   = 17;
  localparam int ADDR_W  = 13;

  logic              clk;
  logic              reset;
  logic [LEN_W-1:0]  length;
  logic              in_valid;
  logic              in_ready;
  logic              in_sys, in_p1, in_p2;
  logic              frame_ready;
  logic [LEN_W-1:0]  frame_len;
  logic [11:0]       tail;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_data;
  logic              frame_done;
  logic              err;

  turbo_deframer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .length(length), .in_valid(in_valid),
    .in_ready(in_ready), .in_sys(in_sys), .in_p1(in_p1), .in_p2(in_p2),
    .frame_ready(frame_ready), .frame_len(frame_len), .tail(tail),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted beats of the current frame.
  int          m_got = 0;
  int          m_k = 0;
  bit          m_held = 1'b0;
  logic [LEN_W-1:0] m_len = '0;
  logic [11:0] m_tail = '0;
  logic        m_err = 1'b0;
  logic [2:0]  m_rd = '0;
  bit          m_rd_chk = 1'b0;
  logic [2:0]  m_pay [MAX_LEN];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_got = 0; m_k = 0; m_held = 1'b0; m_len = '0; m_tail = '0;
      m_err = 1'b0; m_rd = '0; m_rd_chk = 1'b1;
    end else begin
      m_rd_chk = m_held && (int'(rd_addr) < m_k);
      if (m_rd_chk) m_rd = m_pay[rd_addr];
      m_err = 1'b0;
      if (m_held) begin
        if (frame_done) begin
          m_held = 1'b0;
          m_got = 0;
        end
      end else if (in_valid) begin
        if (m_got == 0) begin
          if (int'(length) >= 1 && int'(length) <= MAX_LEN) begin
            m_k = int'(length);
            m_len = length;
            m_pay[0] = {in_sys, in_p1, in_p2};
            m_got = 1;
          end else begin
            m_err = 1'b1;
          end
        end else if (m_got < m_k) begin
          m_pay[m_got] = {in_sys, in_p1, in_p2};
          m_got++;
        end else begin
          m_tail[3*(m_got-m_k) +: 3] = {in_sys, in_p1, in_p2};
          m_got++;
          if (m_got == m_k + 4) m_held = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!m_held));
      chk("frame_ready", 32'(frame_ready), 32'(m_held));
      chk("err", 32'(err), 32'(m_err));
      chk("frame_len", 32'(frame_len), 32'(m_len));
      chk("tail", 32'(tail), 32'(m_tail));
      if (m_rd_chk) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  logic [2:0] pay [MAX_LEN];
  logic [2:0] tl [4];
  logic [2:0] lit5 [5];
  logic [2:0] save0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] b, input logic [LEN_W-1:0] len, input int gap);
    int g = 0;
    while (gap > 0 && g < 16 && int'($urandom_range(99)) < gap) begin
      in_valid = 1'b0;
      length = LEN_W'($urandom);
      tick();
      g++;
    end
    in_valid = 1'b1;
    {in_sys, in_p1, in_p2} = b;
    length = len;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic frame(input int k, input int gap, input bit noise);
    for (int i = 0; i < k; i++) begin
      frame_done = noise && ($urandom_range(9) == 0);
      send(pay[i], (i == 0) ? LEN_W'(k) : LEN_W'($urandom), gap);
    end
    for (int t = 0; t < 4; t++) begin
      frame_done = noise && ($urandom_range(9) == 0);
      send(tl[t], LEN_W'($urandom), gap);
    end
    frame_done = 1'b0;
  endtask

  task automatic hold_release(input int k, input int n);
    chk("hold_len", 32'(frame_len), 32'(k));
    for (int i = 0; i < n; i++) begin
      rd_addr = ADDR_W'($urandom_range(k + 1));
      in_valid = 1'($urandom_range(1));
      {in_sys, in_p1, in_p2} = 3'($urandom);
      length = LEN_W'($urandom_range(1, 8));
      tick();
    end
    in_valid = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("released", 32'(frame_ready), 32'(0));
  endtask

  task automatic rand_frame(input int k);
    for (int i = 0; i < k; i++) pay[i] = 3'($urandom);
    for (int t = 0; t < 4; t++) tl[t] = 3'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; length = '0; in_valid = 1'b0; in_sys = 1'b0; in_p1 = 1'b0;
    in_p2 = 1'b0; rd_addr = '0; frame_done = 1'b0;
    tick();
    started = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_frame_ready", 32'(frame_ready), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    reset = 1'b1;
    tick();

    // Directed length=5 frame
    lit5[0] = 3'b101; lit5[1] = 3'b010; lit5[2] = 3'b111; lit5[3] = 3'b000; lit5[4] = 3'b001;
    for (int i = 0; i < 5; i++) pay[i] = lit5[i];
    tl[0] = 3'b110; tl[1] = 3'b011; tl[2] = 3'b100; tl[3] = 3'b001;
    for (int i = 0; i < 5; i++) send(pay[i], (i == 0) ? LEN_W'(5) : LEN_W'(0), 0);
    for (int t = 0; t < 3; t++) send(tl[t], '0, 0);
    chk("k5_not_ready_beat8", 32'(frame_ready), 32'(0));
    send(tl[3], '0, 0);
    chk("k5_ready_beat9", 32'(frame_ready), 32'(1));
    chk("k5_in_ready", 32'(in_ready), 32'(0));
    chk("k5_len", 32'(frame_len), 32'(5));
    chk("k5_tail", 32'(tail), 32'(12'b001_100_011_110));
    for (int i = 0; i < 5; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      chk("k5_rd", 32'(rd_data), 32'(lit5[i]));
    end
    hold_release(5, 3);

    // length=1, first beat straight into TAIL, accepted right after release
    rand_frame(1);
    save0 = pay[0];
    send(pay[0], LEN_W'(1), 0);
    for (int t = 0; t < 3; t++) send(tl[t], '0, 0);
    chk("k1_not_ready_beat4", 32'(frame_ready), 32'(0));
    send(tl[3], '0, 0);
    chk("k1_ready_beat5", 32'(frame_ready), 32'(1));
    hold_release(1, 3);

    // Invalid lengths
    send(3'b111, '0, 0);
    chk("err_len0", 32'(err), 32'(1));
    chk("err_len0_in_ready", 32'(in_ready), 32'(1));
    send(3'b111, LEN_W'(MAX_LEN + 1), 0);
    chk("err_lenmax1", 32'(err), 32'(1));
    rd_addr = '0;
    tick();
    chk("err_pulse_one_cycle", 32'(err), 32'(0));
    chk("err_no_write", 32'(rd_data), 32'(save0));

    // length=40 gap-free, then same contents with ~50% gaps
    rand_frame(40);
    frame(40, 0, 1'b1);
    hold_release(40, 10);
    frame(40, 50, 1'b1);
    chk("k40_gap_tail", 32'(tail), 32'({tl[3], tl[2], tl[1], tl[0]}));
    hold_release(40, 40);

    // Reset during beat 20 of a length=40 frame
    rand_frame(40);
    for (int i = 0; i < 19; i++) send(pay[i], (i == 0) ? LEN_W'(40) : LEN_W'(0), 0);
    in_valid = 1'b1;
    {in_sys, in_p1, in_p2} = pay[19];
    #2 reset = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_frame_ready", 32'(frame_ready), 32'(0));
    chk("arst_frame_len", 32'(frame_len), 32'(0));
    chk("arst_tail", 32'(tail), 32'(0));
    chk("arst_rd_data", 32'(rd_data), 32'(0));
    chk("arst_err", 32'(err), 32'(0));
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rand_frame(3);
    frame(3, 30, 1'b0);
    chk("k3_ready", 32'(frame_ready), 32'(1));
    hold_release(3, 6);

    // Random frames with gaps, stray frame_done and rejected lengths
    for (int r = 0; r < 12; r++) begin
      int k;
      if ($urandom_range(2) == 0)
        send(3'($urandom), ($urandom_range(1) == 0) ? LEN_W'(0) : LEN_W'(MAX_LEN + 1 + int'($urandom_range(200))), 0);
      k = int'($urandom_range(1, 60));
      rand_frame(k);
      frame(k, int'($urandom_range(0, 60)), 1'b1);
      hold_release(k, int'($urandom_range(2, 8)));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
